pll_rst_seq: RTL and testbench

Parametrised PLL bring-up and reset sequencer that sits beside the PLL wrapper, clocked by the free-running board reference clock. It drives the PLL reset, qualifies the asynchronous `locked` indication (synchronise plus debounce), and retries the PLL on lock timeout. It releases `NUM_DOMAINS` downstream synchronous resets in staggered order, and re-asserts them on lock loss or software request. It replaces ad-hoc `locked`-as-reset usage and counts lock-loss events for debug.

---
 rtl/pll_rst_pkg.sv | 25 ++
 rtl/pll_rst_seq_sync.sv | 23 ++
 rtl/pll_rst_seq.sv | 164 ++++++++++++++++
 tb/tb_pll_rst_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// Shared types and helpers for the PLL bring-up / domain reset sequencer.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_FILTER    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    localparam int STATE_W = 3;

    // One timer serves every phase, so it must hold the longest interval.
    function automatic int timer_width(input int rst_cycles, input int timeout,
                                       input int filt, input int release_span);
        int m;
        m = rst_cycles;
        if (timeout > m) m = timeout;
        if (filt > m) m = filt;
        if (release_span > m) m = release_span;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pll_rst_seq_sync.sv
// Multi-flop synchroniser for a single asynchronous level, cleared to 0 by rst_n.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset / lock qualification / retry, followed by staggered release of the
// downstream domain resets; re-asserts them on lock loss or software request.
module pll_rst_seq
    import pll_rst_pkg::*;
#(
    parameter int NUM_DOMAINS    = 4,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int LOCK_FILT      = 1024,
    parameter int STAGGER        = 8,
    parameter int CNT_W          = 8,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    input  logic                   sw_reset_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic                   all_ready,
    output logic [CNT_W-1:0]       lock_loss_cnt,
    output logic [CNT_W-1:0]       retry_cnt,
    output logic [STATE_W-1:0]     fsm_state
);

    localparam int TW = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_FILT,
                                    STAGGER * NUM_DOMAINS);
    localparam int RW = $clog2(NUM_DOMAINS + 1);

    localparam logic [TW-1:0] RST_LAST     = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] FILT_LAST    = TW'(LOCK_FILT - 1);
    localparam logic [TW-1:0] STAGGER_LAST = TW'(STAGGER - 1);
    localparam logic [RW-1:0] REL_DONE     = RW'(NUM_DOMAINS);
    localparam logic [NUM_DOMAINS-1:0] DOM_FIRST = NUM_DOMAINS'(1);

    state_t          state;
    logic [TW-1:0]   timer;
    logic [RW-1:0]   rel_idx;
    logic            lock_s;
    logic            lock_lost;
    logic            timed_out;
    logic            sw_restart;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (pll_locked),
        .q    (lock_s)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Event qualifiers are evaluated independently of the next-state choice so
    // the counters still see an event that coincides with a software restart.
    assign lock_lost  = !lock_s && (state == ST_RELEASE || state == ST_RUN);
    assign timed_out  = !lock_s && (state == ST_WAIT_LOCK) && (timer == TIMEOUT_LAST);
    assign sw_restart = sw_reset_req && (state != ST_PLL_RST);
    assign fsm_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_PLL_RST;
            timer         <= '0;
            rel_idx       <= '0;
            pll_rst       <= 1'b1;
            dom_rst_n     <= '0;
            all_ready     <= 1'b0;
            lock_loss_cnt <= '0;
            retry_cnt     <= '0;
        end else begin
            if (lock_lost) lock_loss_cnt <= sat_inc(lock_loss_cnt);
            if (timed_out) retry_cnt     <= sat_inc(retry_cnt);

            if (sw_restart) begin
                state     <= ST_PLL_RST;
                timer     <= '0;
                rel_idx   <= '0;
                pll_rst   <= 1'b1;
                dom_rst_n <= '0;
                all_ready <= 1'b0;
            end else begin
                case (state)
                    ST_PLL_RST: begin
                        if (timer == RST_LAST) begin
                            state   <= ST_WAIT_LOCK;
                            timer   <= '0;
                            pll_rst <= 1'b0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (lock_s) begin
                            state <= ST_FILTER;
                            timer <= '0;
                        end else if (timer == TIMEOUT_LAST) begin
                            state   <= ST_PLL_RST;
                            timer   <= '0;
                            pll_rst <= 1'b1;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    ST_FILTER: begin
                        if (!lock_s) begin
                            state <= ST_WAIT_LOCK;
                            timer <= '0;
                        end else if (timer == FILT_LAST) begin
                            state     <= ST_RELEASE;
                            timer     <= '0;
                            rel_idx   <= RW'(1);
                            dom_rst_n <= DOM_FIRST;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    ST_RELEASE: begin
                        // Domains release in index order, so a left shift filling
                        // with ones walks the thermometer code one bit at a time.
                        if (!lock_s) begin
                            state     <= ST_WAIT_LOCK;
                            timer     <= '0;
                            rel_idx   <= '0;
                            dom_rst_n <= '0;
                        end else if (rel_idx == REL_DONE) begin
                            state     <= ST_RUN;
                            timer     <= '0;
                            all_ready <= 1'b1;
                        end else if (timer == STAGGER_LAST) begin
                            timer     <= '0;
                            rel_idx   <= rel_idx + RW'(1);
                            dom_rst_n <= (dom_rst_n << 1) | DOM_FIRST;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    ST_RUN: begin
                        if (!lock_s) begin
                            state     <= ST_WAIT_LOCK;
                            timer     <= '0;
                            rel_idx   <= '0;
                            dom_rst_n <= '0;
                            all_ready <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= ST_PLL_RST;
                        timer     <= '0;
                        rel_idx   <= '0;
                        pll_rst   <= 1'b1;
                        dom_rst_n <= '0;
                        all_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed-random bench for pll_rst_seq; expectations come from timing arithmetic
// on pin events (rise/drop cycle numbers), not from a copy of the state machine.
module tb_pll_rst_seq;
    import pll_rst_pkg::*;

    localparam int N    = 3;
    localparam int PRC  = 4;
    localparam int T    = 64;
    localparam int F    = 8;
    localparam int S    = 3;
    localparam int CW   = 2;
    localparam int SS   = 2;
    localparam int REL0 = F + 1 + SS;              // pin rise -> dom_rst_n[0]
    localparam int RDY  = REL0 + S * (N - 1) + 1;  // pin rise -> all_ready
    localparam int LOSS = SS + 1;                  // pin drop -> domains reset
    localparam int PER  = PRC + T;                 // retry period
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [N-1:0] DOM_ALL = '1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pll_locked = 1'b0;
    logic          sw_reset_req = 1'b0;
    logic          pll_rst;
    logic [N-1:0]  dom_rst_n;
    logic          all_ready;
    logic [CW-1:0] lock_loss_cnt;
    logic [CW-1:0] retry_cnt;
    logic [2:0]    fsm_state;

    int ec = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    pll_rst_seq #(
        .NUM_DOMAINS(N), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(T), .LOCK_FILT(F),
        .STAGGER(S), .CNT_W(CW), .SYNC_STAGES(SS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .sw_reset_req (sw_reset_req),
        .pll_rst      (pll_rst),
        .dom_rst_n    (dom_rst_n),
        .all_ready    (all_ready),
        .lock_loss_cnt(lock_loss_cnt),
        .retry_cnt    (retry_cnt),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish by t=200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ec++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, ec);
        end
    endtask

    task automatic chk_counters(input int loss, input int retry);
        chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(loss));
        chk("retry_cnt", 32'(retry_cnt), 32'(retry));
    endtask

    // Domains released t cycles after the pin rose (already-stable lock).
    function automatic logic [N-1:0] dom_model(input int t);
        dom_model = '0;
        for (int k = 0; k < N; k++)
            if (t >= REL0 + S * k) dom_model[k] = 1'b1;
    endfunction

    // Pin rises at cycle rise_ec; pll_rst expected high in [rst_from, rst_from+PRC).
    task automatic track_release(input int rise_ec, input int end_ec, input int rst_from);
        while (ec < end_ec) begin
            if (ec == rise_ec) pll_locked = 1'b1;
            tick();
            chk("pll_rst", 32'(pll_rst), 32'(ec >= rst_from && ec < rst_from + PRC));
            chk("dom_rst_n", 32'(dom_rst_n), 32'(dom_model(ec - rise_ec)));
            chk("all_ready", 32'(all_ready), 32'(ec - rise_ec >= RDY));
        end
    endtask

    // From RUN: drop the pin, re-lock it, and follow the second staggered release.
    task automatic loss_relock(input int loss_before, input int loss_after);
        int d;
        int r;
        int stop;
        d = ec + $urandom_range(1, 20);
        r = d + $urandom_range(1, 10);
        stop = r + RDY + 2;
        while (ec < stop) begin
            if (ec == d) pll_locked = 1'b0;
            if (ec == r) pll_locked = 1'b1;
            tick();
            chk("loss_pll_rst", 32'(pll_rst), 32'(0));
            if (ec < d + LOSS) begin
                chk("loss_dom_hold", 32'(dom_rst_n), 32'(DOM_ALL));
                chk("loss_ready_hold", 32'(all_ready), 32'(1));
                chk("loss_cnt_before", 32'(lock_loss_cnt), 32'(loss_before));
            end else begin
                chk("loss_dom", 32'(dom_rst_n), 32'(dom_model(ec - r)));
                chk("loss_ready", 32'(all_ready), 32'(ec - r >= RDY));
                chk("loss_cnt_after", 32'(lock_loss_cnt), 32'(loss_after));
            end
            if (ec == d + LOSS) chk("loss_state", 32'(fsm_state), 32'(ST_WAIT_LOCK));
        end
    endtask

    initial begin
        int d_rise;
        int d;
        int r;
        int ecf;
        int stop;
        int rise;
        int x;
        int es;
        int p;
        int h;
        int t0;
        int n;
        int q;
        int e0;

        // Reset values while rst_n is held low.
        repeat (3) tick();
        chk("rst_pll_rst", 32'(pll_rst), 32'(1));
        chk("rst_dom", 32'(dom_rst_n), 32'(0));
        chk("rst_ready", 32'(all_ready), 32'(0));
        chk("rst_state", 32'(fsm_state), 32'(ST_PLL_RST));
        chk_counters(0, 0);

        // Normal bring-up.
        rst_n = 1'b1;
        ec = 0;
        d_rise = $urandom_range(2, 40);
        track_release(d_rise, d_rise + RDY + 2, 0);
        chk("bringup_state", 32'(fsm_state), 32'(ST_RUN));
        chk_counters(0, 0);

        // Lock loss in RUN, then re-lock.
        loss_relock(0, 1);
        chk("relock_state", 32'(fsm_state), 32'(ST_RUN));

        // Lock loss from RUN, re-lock, then sw_reset_req coincident with a
        // second lock loss while still in RELEASE with bit 0 already out.
        d = ec + $urandom_range(1, 20);
        r = d + $urandom_range(1, 10);
        ecf = r + $urandom_range(12, 18);
        stop = ecf + PRC;
        while (ec < stop) begin
            if (ec == d) pll_locked = 1'b0;
            if (ec == r) pll_locked = 1'b1;
            if (ec == ecf - 3) pll_locked = 1'b0;
            sw_reset_req = (ec == ecf - 1);
            tick();
            chk("conc_pll_rst", 32'(pll_rst), 32'(ec >= ecf && ec < ecf + PRC));
            if (ec < d + LOSS) begin
                chk("conc_dom_run", 32'(dom_rst_n), 32'(DOM_ALL));
                chk("conc_ready_run", 32'(all_ready), 32'(1));
                chk("conc_loss_1", 32'(lock_loss_cnt), 32'(1));
            end else if (ec < ecf) begin
                chk("conc_dom_rel", 32'(dom_rst_n), 32'(dom_model(ec - r)));
                chk("conc_ready_rel", 32'(all_ready), 32'(0));
                chk("conc_loss_2", 32'(lock_loss_cnt), 32'(2));
            end else begin
                chk("conc_dom_rst", 32'(dom_rst_n), 32'(0));
                chk("conc_ready_rst", 32'(all_ready), 32'(0));
                chk("conc_loss_3", 32'(lock_loss_cnt), 32'(3));
            end
            if (ec == ecf) chk("conc_state", 32'(fsm_state), 32'(ST_PLL_RST));
        end
        sw_reset_req = 1'b0;
        chk("conc_state_wait", 32'(fsm_state), 32'(ST_WAIT_LOCK));

        // One-cycle lock glitch inside FILTER: release schedule restarts on re-lock.
        rise = ec + $urandom_range(0, 20);
        x = rise + $urandom_range(1, 8);
        track_release(rise, x, -100);
        pll_locked = 1'b0;
        track_release(x + 1, x + 1 + RDY + 2, -100);
        chk("glitch_state", 32'(fsm_state), 32'(ST_RUN));
        chk_counters(3, 0);

        // Software restart from RUN, short lock pulse (FILTER abort), then
        // repeated timeouts; a request inside PLL_RST must not stretch the pulse.
        es = ec + $urandom_range(2, 6);
        p = es + PRC + $urandom_range(5, 30);
        h = $urandom_range(1, 8);
        t0 = p + h + 3 + T;
        stop = t0 + 3 * PER + PRC + 2;
        while (ec < stop) begin
            sw_reset_req = (ec == es - 1) || (ec == t0 + 1);
            if (ec == es) pll_locked = 1'b0;
            if (ec == p) pll_locked = 1'b1;
            if (ec == p + h) pll_locked = 1'b0;
            tick();
            n = (ec >= t0) ? (ec - t0) / PER + 1 : 0;
            if (n > CMAX) n = CMAX;
            chk("to_pll_rst", 32'(pll_rst),
                32'((ec >= es && ec < es + PRC) || (ec >= t0 && (ec - t0) % PER < PRC)));
            chk("to_dom", 32'(dom_rst_n), 32'((ec < es) ? DOM_ALL : '0));
            chk("to_ready", 32'(all_ready), 32'(ec < es));
            chk("to_retry", 32'(retry_cnt), 32'(n));
            if (ec == t0) chk("to_state", 32'(fsm_state), 32'(ST_PLL_RST));
        end
        sw_reset_req = 1'b0;
        chk_counters(3, 3);

        // Re-lock after timeouts, then a saturating lock loss.
        q = ec + $urandom_range(0, 20);
        track_release(q, q + RDY + $urandom_range(1, 10), -100);
        loss_relock(3, 3);

        // Asynchronous reset mid-RUN, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pll_rst", 32'(pll_rst), 32'(1));
        chk("async_dom", 32'(dom_rst_n), 32'(0));
        chk("async_ready", 32'(all_ready), 32'(0));
        chk("async_state", 32'(fsm_state), 32'(ST_PLL_RST));
        chk_counters(0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        e0 = ec;
        // Pin is already high; the cleared synchroniser makes it look like a
        // rise at the release cycle, seen once WAIT_LOCK is reached.
        track_release(e0 + 2, e0 + 2 + RDY + 2, e0);
        chk("restart_state", 32'(fsm_state), 32'(ST_RUN));
        chk_counters(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
